mem_stage: RTL and testbench

//  MEM pipeline stage; consumes the EX/MEM register outputs and owns the EX_MEM -> MEM_WB boundary.

---
 rtl/pipeline_pkg.sv | 43 ++++
 rtl/mem_lsu_format.sv | 64 ++++++
 rtl/mem_stage.sv | 190 +++++++++++++++++++
 tb/tb_mem_stage.sv | 387 ++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/pipeline_pkg.sv
// Shared pipeline definitions for the MEM stage.
//  - funct3 access-size encodings for loads and stores
//  - MEM stage FSM state encoding (IDLE=0, REQ=1, RESP=2)
//  - latched memory-op and MEM_WB bundle types, with NOP constants
package pipeline_pkg;

  localparam logic [2:0] F3_B  = 3'b000;  // LB / SB
  localparam logic [2:0] F3_H  = 3'b001;  // LH / SH
  localparam logic [2:0] F3_W  = 3'b010;  // LW / SW
  localparam logic [2:0] F3_BU = 3'b100;  // LBU
  localparam logic [2:0] F3_HU = 3'b101;  // LHU

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_RESP = 2'd2
  } mem_state_e;

  // Memory op captured on the edge it leaves EX_MEM, so the bus can be
  // held stable while the upstream register is bubbled.
  typedef struct packed {
    logic [31:0] addr;      // full effective address (low bits select lanes)
    logic [31:0] wdata;     // lane-replicated store data
    logic [3:0]  be;
    logic [2:0]  funct3;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
    logic        is_load;
  } mem_op_t;

  typedef struct packed {
    logic [31:0] alu_result;
    logic [31:0] mem_data;
    logic [4:0]  rd;
    logic        regwrite;
    logic        memtoreg;
  } wb_t;

  localparam mem_op_t OP_NOP = '0;
  localparam wb_t     WB_NOP = '0;

endpackage

// File: rtl/mem_lsu_format.sv
// Byte-lane formatting for the data-memory bus (purely combinational).
// Ports:
//  funct3    in   3   access size/sign
//  off       in   2   address byte offset
//  rs2       in   32  raw store data
//  rdata     in   32  raw load word from the bus
//  be        out  4   byte enables for the access
//  wdata     out  32  store data replicated across byte lanes
//  load_data out  32  load data shifted down and sign/zero extended
//  misalign  out  1   half on an odd address or word not on a 4-byte boundary
module mem_lsu_format
  import pipeline_pkg::*;
(
  input  logic [2:0]  funct3,
  input  logic [1:0]  off,
  input  logic [31:0] rs2,
  input  logic [31:0] rdata,
  output logic [3:0]  be,
  output logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic        misalign
);

  logic [31:0] shifted;

  assign shifted = rdata >> {off, 3'b000};

  always_comb begin
    // NOTE: every output gets a default before the case so no path can
    // leave one unassigned and infer a latch.
    be        = 4'b1111;
    wdata     = rs2;
    load_data = shifted;
    misalign  = |off;
    case (funct3)
      F3_B: begin
        be        = 4'b0001 << off;
        wdata     = {4{rs2[7:0]}};
        load_data = {{24{shifted[7]}}, shifted[7:0]};
        misalign  = 1'b0;
      end
      F3_BU: begin
        be        = 4'b0001 << off;
        wdata     = {4{rs2[7:0]}};
        load_data = {24'h0, shifted[7:0]};
        misalign  = 1'b0;
      end
      F3_H: begin
        be        = 4'b0011 << off;
        wdata     = {2{rs2[15:0]}};
        load_data = {{16{shifted[15]}}, shifted[15:0]};
        misalign  = off[0];
      end
      F3_HU: begin
        be        = 4'b0011 << off;
        wdata     = {2{rs2[15:0]}};
        load_data = {16'h0, shifted[15:0]};
        misalign  = off[0];
      end
      default: ;  // word, including unlisted encodings
    endcase
  end

endmodule

// File: rtl/mem_stage.sv
// MEM pipeline stage: issues loads/stores on the data-memory bus, stalls
// the pipeline while an access is outstanding and registers the writeback
// bundle into MEM_WB_*.
// Ports:
//  clk, reset            clock; synchronous active-low reset
//  EX_MEM_*              EX/MEM register outputs (address/result, store
//                        data, funct3, memread/memwrite/memtoreg/regwrite, rd)
//  dmem_req/we/addr/     request channel, req held until dmem_ready
//   wdata/be, dmem_ready
//  dmem_rvalid/rdata     load response channel
//  MEM_stall             combinational stall to the upstream pipeline
//  MEM_misalign          one-cycle pulse for a dropped misaligned access
//  MEM_WB_*              registered writeback bundle
module mem_stage
  import pipeline_pkg::*;
#(
  parameter int XLEN = 32,
  parameter int BE_W = XLEN / 8
) (
  input  logic            clk,
  input  logic            reset,
  input  logic [XLEN-1:0] EX_MEM_ALU_result,
  input  logic [XLEN-1:0] EX_MEM_rs2_data,
  input  logic [2:0]      EX_MEM_funct3,
  input  logic            EX_MEM_memread,
  input  logic            EX_MEM_memwrite,
  input  logic            EX_MEM_memtoreg,
  input  logic            EX_MEM_regwrite,
  input  logic [4:0]      EX_MEM_rd,
  output logic            dmem_req,
  output logic            dmem_we,
  output logic [XLEN-1:0] dmem_addr,
  output logic [XLEN-1:0] dmem_wdata,
  output logic [BE_W-1:0] dmem_be,
  input  logic            dmem_ready,
  input  logic            dmem_rvalid,
  input  logic [XLEN-1:0] dmem_rdata,
  output logic            MEM_stall,
  output logic            MEM_misalign,
  output logic [XLEN-1:0] MEM_WB_ALU_result,
  output logic [XLEN-1:0] MEM_WB_mem_data,
  output logic [4:0]      MEM_WB_rd,
  output logic            MEM_WB_regwrite,
  output logic            MEM_WB_memtoreg
);

  mem_state_e state_q, state_d;
  mem_op_t    op_q, cur_op;
  wb_t        wb_q, wb_d;
  logic       misalign_q, misalign_evt, complete;
  logic       in_idle, cur_mem, cur_load;

  logic [2:0]  fmt_funct3;
  logic [1:0]  fmt_off;
  logic [3:0]  fmt_be;
  logic [31:0] fmt_wdata, fmt_load;
  logic        fmt_misalign;

  assign in_idle  = (state_q == ST_IDLE);
  assign cur_mem  = EX_MEM_memread | EX_MEM_memwrite;
  assign cur_load = EX_MEM_memread;  // read+write together counts as a load

  // In IDLE the formatter sees the live EX_MEM op; afterwards the latched
  // copy, so the response is formatted with the op that issued it.
  assign fmt_funct3 = in_idle ? EX_MEM_funct3 : op_q.funct3;
  assign fmt_off    = in_idle ? EX_MEM_ALU_result[1:0] : op_q.addr[1:0];

  mem_lsu_format u_fmt (
    .funct3    (fmt_funct3),
    .off       (fmt_off),
    .rs2       (EX_MEM_rs2_data),
    .rdata     (dmem_rdata),
    .be        (fmt_be),
    .wdata     (fmt_wdata),
    .load_data (fmt_load),
    .misalign  (fmt_misalign)
  );

  always_comb begin
    cur_op          = OP_NOP;
    cur_op.addr     = EX_MEM_ALU_result;
    cur_op.wdata    = fmt_wdata;
    cur_op.be       = fmt_be;
    cur_op.funct3   = EX_MEM_funct3;
    cur_op.rd       = EX_MEM_rd;
    cur_op.regwrite = EX_MEM_regwrite;
    cur_op.memtoreg = EX_MEM_memtoreg;
    cur_op.is_load  = cur_load;
  end

  // State register
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments so every
    // register samples pre-edge values regardless of block ordering.
    if (!reset) state_q <= ST_IDLE;
    else        state_q <= state_d;
  end

  // Next-state logic
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE: begin
        if (cur_mem && !fmt_misalign) begin
          if (cur_load)         state_d = dmem_ready ? ST_RESP : ST_REQ;
          else if (!dmem_ready) state_d = ST_REQ;
        end
      end
      ST_REQ: begin
        if (dmem_ready) state_d = op_q.is_load ? ST_RESP : ST_IDLE;
      end
      ST_RESP: begin
        if (dmem_rvalid) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // Output logic: bus drive, stall, completion and the writeback bundle
  always_comb begin
    dmem_req     = 1'b0;
    dmem_we      = 1'b0;
    dmem_addr    = {op_q.addr[31:2], 2'b00};
    dmem_wdata   = op_q.wdata;
    dmem_be      = op_q.be;
    MEM_stall    = 1'b0;
    complete     = 1'b0;
    misalign_evt = 1'b0;
    wb_d            = WB_NOP;
    wb_d.alu_result = op_q.addr;
    wb_d.rd         = op_q.rd;
    wb_d.regwrite   = op_q.regwrite;
    wb_d.memtoreg   = op_q.memtoreg;
    case (state_q)
      ST_IDLE: begin
        // A fresh op drives the bus straight from EX_MEM in its first cycle.
        dmem_addr       = {EX_MEM_ALU_result[31:2], 2'b00};
        dmem_wdata      = fmt_wdata;
        dmem_be         = fmt_be;
        wb_d.alu_result = EX_MEM_ALU_result;
        wb_d.rd         = EX_MEM_rd;
        wb_d.regwrite   = EX_MEM_regwrite;
        wb_d.memtoreg   = EX_MEM_memtoreg;
        if (!cur_mem) begin
          complete = 1'b1;
        end else if (fmt_misalign) begin
          misalign_evt = 1'b1;
        end else begin
          dmem_req = 1'b1;
          dmem_we  = ~cur_load;
          if (!cur_load && dmem_ready) complete  = 1'b1;
          else                         MEM_stall = 1'b1;
        end
      end
      ST_REQ: begin
        dmem_req = 1'b1;
        dmem_we  = ~op_q.is_load;
        if (!op_q.is_load && dmem_ready) complete  = 1'b1;
        else                             MEM_stall = 1'b1;
      end
      ST_RESP: begin
        wb_d.mem_data = fmt_load;
        if (dmem_rvalid) complete  = 1'b1;
        else             MEM_stall = 1'b1;
      end
      default: ;
    endcase
  end

  // Latched op and MEM_WB registers
  always_ff @(posedge clk) begin
    if (!reset) begin
      op_q       <= OP_NOP;
      wb_q       <= WB_NOP;
      misalign_q <= 1'b0;
    end else begin
      if (in_idle && cur_mem && !fmt_misalign) op_q <= cur_op;
      wb_q       <= complete ? wb_d : WB_NOP;  // bubble on stall/misalign
      misalign_q <= misalign_evt;
    end
  end

  assign MEM_misalign      = misalign_q;
  assign MEM_WB_ALU_result = wb_q.alu_result;
  assign MEM_WB_mem_data   = wb_q.mem_data;
  assign MEM_WB_rd         = wb_q.rd;
  assign MEM_WB_regwrite   = wb_q.regwrite;
  assign MEM_WB_memtoreg   = wb_q.memtoreg;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage. Inputs change on the falling edge;
// combinational outputs are sampled 1ns later, registered outputs 1ns
// after the rising edge.
module tb_mem_stage;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] EX_MEM_ALU_result, EX_MEM_rs2_data;
  logic [2:0]  EX_MEM_funct3;
  logic        EX_MEM_memread, EX_MEM_memwrite, EX_MEM_memtoreg, EX_MEM_regwrite;
  logic [4:0]  EX_MEM_rd;
  logic        dmem_req, dmem_we;
  logic [31:0] dmem_addr, dmem_wdata;
  logic [3:0]  dmem_be;
  logic        dmem_ready, dmem_rvalid;
  logic [31:0] dmem_rdata;
  logic        MEM_stall, MEM_misalign;
  logic [31:0] MEM_WB_ALU_result, MEM_WB_mem_data;
  logic [4:0]  MEM_WB_rd;
  logic        MEM_WB_regwrite, MEM_WB_memtoreg;

  int tests_run    = 0;
  int tests_failed = 0;

  mem_stage dut (
    .clk               (clk),
    .reset             (reset),
    .EX_MEM_ALU_result (EX_MEM_ALU_result),
    .EX_MEM_rs2_data   (EX_MEM_rs2_data),
    .EX_MEM_funct3     (EX_MEM_funct3),
    .EX_MEM_memread    (EX_MEM_memread),
    .EX_MEM_memwrite   (EX_MEM_memwrite),
    .EX_MEM_memtoreg   (EX_MEM_memtoreg),
    .EX_MEM_regwrite   (EX_MEM_regwrite),
    .EX_MEM_rd         (EX_MEM_rd),
    .dmem_req          (dmem_req),
    .dmem_we           (dmem_we),
    .dmem_addr         (dmem_addr),
    .dmem_wdata        (dmem_wdata),
    .dmem_be           (dmem_be),
    .dmem_ready        (dmem_ready),
    .dmem_rvalid       (dmem_rvalid),
    .dmem_rdata        (dmem_rdata),
    .MEM_stall         (MEM_stall),
    .MEM_misalign      (MEM_misalign),
    .MEM_WB_ALU_result (MEM_WB_ALU_result),
    .MEM_WB_mem_data   (MEM_WB_mem_data),
    .MEM_WB_rd         (MEM_WB_rd),
    .MEM_WB_regwrite   (MEM_WB_regwrite),
    .MEM_WB_memtoreg   (MEM_WB_memtoreg)
  );

  always #5 clk = ~clk;

  // {ALU_result, mem_data, rd, regwrite, memtoreg}
  function automatic logic [70:0] wb_obs();
    return {MEM_WB_ALU_result, MEM_WB_mem_data, MEM_WB_rd, MEM_WB_regwrite, MEM_WB_memtoreg};
  endfunction

  function automatic logic [70:0] wb_exp(input logic [31:0] alu, input logic [31:0] md,
                                         input logic [4:0] rd, input logic rw, input logic m2r);
    return {alu, md, rd, rw, m2r};
  endfunction

  task automatic drive_op(input logic [31:0] alu, input logic [31:0] rs2, input logic [2:0] f3,
                          input logic rd_en, input logic wr_en, input logic m2r,
                          input logic rw, input logic [4:0] rd);
    EX_MEM_ALU_result = alu;
    EX_MEM_rs2_data   = rs2;
    EX_MEM_funct3     = f3;
    EX_MEM_memread    = rd_en;
    EX_MEM_memwrite   = wr_en;
    EX_MEM_memtoreg   = m2r;
    EX_MEM_regwrite   = rw;
    EX_MEM_rd         = rd;
  endtask

  task automatic drive_bubble();
    drive_op(32'h0, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b0, 5'd0);
  endtask

  task automatic test_reset();
    reset = 1'b0;
    drive_bubble();
    dmem_ready = 1'b0; dmem_rvalid = 1'b0; dmem_rdata = 32'h0;
    repeat (2) @(posedge clk);
    #1;
    tests_run++;
    if ({wb_obs(), MEM_misalign, dmem_req, MEM_stall} !== 74'h0) begin
      tests_failed++;
      $display("FAIL reset_state: wb=%h misalign=%b req=%b stall=%b, required all 0",
               wb_obs(), MEM_misalign, dmem_req, MEM_stall);
    end
    @(negedge clk); reset = 1'b1;
  endtask

  task automatic test_alu_op();
    @(negedge clk);
    drive_op(32'h1234, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd5);
    #1;
    tests_run++;
    if ({MEM_stall, dmem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL alu_no_stall: stall=%b req=%b, required 0 0", MEM_stall, dmem_req);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wb_obs() !== wb_exp(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0)) begin
      tests_failed++;
      $display("FAIL alu_wb: got %h required %h", wb_obs(), wb_exp(32'h1234, 32'h0, 5'd5, 1'b1, 1'b0));
    end
    @(negedge clk); drive_bubble();
  endtask

  task automatic test_stores();
    logic [31:0] addr [3];
    logic [31:0] rs2  [3];
    logic [2:0]  f3   [3];
    logic [31:0] ewd  [3];
    logic [3:0]  ebe  [3];
    addr = '{32'h103, 32'h202, 32'h300};
    rs2  = '{32'h123456AB, 32'h1234BEEF, 32'hCAFEF00D};
    f3   = '{3'b000, 3'b001, 3'b010};
    ewd  = '{32'hABABABAB, 32'hBEEFBEEF, 32'hCAFEF00D};
    ebe  = '{4'b1000, 4'b1100, 4'b1111};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(addr[i], rs2[i], f3[i], 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
      dmem_ready = 1'b1;
      #1;
      tests_run++;
      if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_stall} !==
          {1'b1, 1'b1, {addr[i][31:2], 2'b00}, ebe[i], ewd[i], 1'b0}) begin
        tests_failed++;
        $display("FAIL store_bus[%0d]: req=%b we=%b addr=%h be=%b wdata=%h stall=%b, required 1 1 %h %b %h 0",
                 i, dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_stall,
                 {addr[i][31:2], 2'b00}, ebe[i], ewd[i]);
      end
      @(posedge clk); #1;
      tests_run++;
      if (wb_obs() !== wb_exp(addr[i], 32'h0, 5'd0, 1'b0, 1'b0)) begin
        tests_failed++;
        $display("FAIL store_wb[%0d]: got %h required %h", i, wb_obs(),
                 wb_exp(addr[i], 32'h0, 5'd0, 1'b0, 1'b0));
      end
    end
    @(negedge clk); drive_bubble(); dmem_ready = 1'b0;
  endtask

  task automatic test_store_wait();
    @(negedge clk);
    drive_op(32'h404, 32'h11223344, 3'b010, 1'b0, 1'b1, 1'b0, 1'b0, 5'd0);
    dmem_ready = 1'b0;
    #1;
    tests_run++;
    if ({dmem_req, MEM_stall} !== 2'b11) begin
      tests_failed++;
      $display("FAIL store_wait_stall: req=%b stall=%b, required 1 1", dmem_req, MEM_stall);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wb_obs() !== 71'h0) begin
      tests_failed++;
      $display("FAIL store_wait_bubble: got %h required 0", wb_obs());
    end
    @(negedge clk); drive_bubble(); dmem_ready = 1'b1;
    #1;
    tests_run++;
    if ({dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_stall} !==
        {1'b1, 1'b1, 32'h404, 4'b1111, 32'h11223344, 1'b0}) begin
      tests_failed++;
      $display("FAIL store_wait_held: req=%b we=%b addr=%h be=%b wdata=%h stall=%b, required 1 1 404 1111 11223344 0",
               dmem_req, dmem_we, dmem_addr, dmem_be, dmem_wdata, MEM_stall);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wb_obs() !== wb_exp(32'h404, 32'h0, 5'd0, 1'b0, 1'b0)) begin
      tests_failed++;
      $display("FAIL store_wait_wb: got %h required %h", wb_obs(), wb_exp(32'h404, 32'h0, 5'd0, 1'b0, 1'b0));
    end
    @(negedge clk); dmem_ready = 1'b0;
  endtask

  // LB/LBU at 0x102, accepted at once, rvalid three cycles later.
  task automatic test_load_byte(input logic [2:0] f3, input logic [31:0] exp_data, input string name);
    int stall_cnt = 0;
    int early_wr  = 0;
    @(negedge clk);
    drive_op(32'h102, 32'h0, f3, 1'b1, 1'b0, 1'b1, 1'b1, 5'd7);
    dmem_ready = 1'b1; dmem_rvalid = 1'b0;
    #1;
    if (MEM_stall) stall_cnt++;
    tests_run++;
    if ({dmem_req, dmem_we, dmem_addr} !== {1'b1, 1'b0, 32'h100}) begin
      tests_failed++;
      $display("FAIL %s_req: req=%b we=%b addr=%h, required 1 0 00000100", name, dmem_req, dmem_we, dmem_addr);
    end
    @(posedge clk); #1;
    if (MEM_WB_regwrite) early_wr++;
    for (int cyc = 1; cyc <= 3; cyc++) begin
      @(negedge clk);
      drive_bubble();
      dmem_ready  = 1'b0;
      dmem_rvalid = (cyc == 3);
      dmem_rdata  = (cyc == 3) ? 32'h00800000 : 32'hFFFFFFFF;
      #1;
      if (MEM_stall) stall_cnt++;
      @(posedge clk); #1;
      if (cyc < 3 && MEM_WB_regwrite) early_wr++;
    end
    tests_run++;
    if (stall_cnt != 3 || early_wr != 0) begin
      tests_failed++;
      $display("FAIL %s_stall: stall cycles=%0d early writes=%0d, required 3 and 0", name, stall_cnt, early_wr);
    end
    tests_run++;
    if (wb_obs() !== wb_exp(32'h102, exp_data, 5'd7, 1'b1, 1'b1)) begin
      tests_failed++;
      $display("FAIL %s_wb: got %h required %h", name, wb_obs(), wb_exp(32'h102, exp_data, 5'd7, 1'b1, 1'b1));
    end
    @(negedge clk); dmem_rvalid = 1'b0;
  endtask

  task automatic test_load_wait();
    int req_cnt = 0, stall_cnt = 0, wr_cnt = 0, bad_bus = 0;
    for (int cyc = 0; cyc < 4; cyc++) begin
      @(negedge clk);
      if (cyc == 0) drive_op(32'h40, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd9);
      else          drive_bubble();
      dmem_ready  = (cyc == 2);
      dmem_rvalid = (cyc == 3);
      dmem_rdata  = (cyc == 3) ? 32'hDEADBEEF : 32'h5A5A5A5A;
      #1;
      if (dmem_req) begin
        req_cnt++;
        if ({dmem_addr, dmem_be, dmem_we} !== {32'h40, 4'b1111, 1'b0}) bad_bus++;
      end
      if (MEM_stall) stall_cnt++;
      @(posedge clk); #1;
      if (MEM_WB_regwrite) wr_cnt++;
    end
    tests_run++;
    if (req_cnt != 3 || bad_bus != 0) begin
      tests_failed++;
      $display("FAIL lw_req_hold: req cycles=%0d unstable=%0d, required 3 and 0", req_cnt, bad_bus);
    end
    tests_run++;
    if (stall_cnt != 3 || wr_cnt != 1) begin
      tests_failed++;
      $display("FAIL lw_stall_wr: stall=%0d writes=%0d, required 3 and 1", stall_cnt, wr_cnt);
    end
    tests_run++;
    if (wb_obs() !== wb_exp(32'h40, 32'hDEADBEEF, 5'd9, 1'b1, 1'b1)) begin
      tests_failed++;
      $display("FAIL lw_wb: got %h required %h", wb_obs(), wb_exp(32'h40, 32'hDEADBEEF, 5'd9, 1'b1, 1'b1));
    end
    @(negedge clk); dmem_rvalid = 1'b0;
  endtask

  // Half/byte extension at other offsets, one-cycle response.
  task automatic test_load_formats();
    logic [2:0]  f3   [3];
    logic [31:0] addr [3];
    logic [31:0] rd_w [3];
    logic [31:0] exp  [3];
    f3   = '{3'b001, 3'b101, 3'b000};
    addr = '{32'h42, 32'h42, 32'h81};
    rd_w = '{32'h80017F00, 32'h80017F00, 32'h00007F00};
    exp  = '{32'hFFFF8001, 32'h00008001, 32'h0000007F};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(addr[i], 32'h0, f3[i], 1'b1, 1'b0, 1'b1, 1'b1, 5'd3);
      dmem_ready = 1'b1; dmem_rvalid = 1'b0;
      @(posedge clk);
      @(negedge clk);
      drive_bubble();
      dmem_ready = 1'b0; dmem_rvalid = 1'b1; dmem_rdata = rd_w[i];
      @(posedge clk); #1;
      tests_run++;
      if (wb_obs() !== wb_exp(addr[i], exp[i], 5'd3, 1'b1, 1'b1)) begin
        tests_failed++;
        $display("FAIL load_fmt[%0d]: got %h required %h", i, wb_obs(), wb_exp(addr[i], exp[i], 5'd3, 1'b1, 1'b1));
      end
      @(negedge clk); dmem_rvalid = 1'b0;
    end
  endtask

  task automatic test_misalign();
    logic [2:0]  f3   [3];
    logic [31:0] addr [3];
    logic        ld   [3];
    f3   = '{3'b001, 3'b010, 3'b010};
    addr = '{32'h101, 32'h102, 32'h203};
    ld   = '{1'b1, 1'b1, 1'b0};
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      drive_op(addr[i], 32'h0, f3[i], ld[i], ~ld[i], ld[i], ld[i], 5'd4);
      dmem_ready = 1'b1;
      #1;
      tests_run++;
      if ({dmem_req, MEM_stall} !== 2'b00) begin
        tests_failed++;
        $display("FAIL misalign_bus[%0d]: req=%b stall=%b, required 0 0", i, dmem_req, MEM_stall);
      end
      @(posedge clk); #1;
      tests_run++;
      if ({MEM_misalign, wb_obs()} !== {1'b1, 71'h0}) begin
        tests_failed++;
        $display("FAIL misalign_pulse[%0d]: misalign=%b wb=%h, required 1 and 0", i, MEM_misalign, wb_obs());
      end
      @(negedge clk); drive_bubble(); dmem_ready = 1'b0;
      @(posedge clk); #1;
      tests_run++;
      if (MEM_misalign !== 1'b0) begin
        tests_failed++;
        $display("FAIL misalign_width[%0d]: misalign=%b, required 0", i, MEM_misalign);
      end
    end
  endtask

  task automatic test_reset_in_resp();
    @(negedge clk);
    drive_op(32'h80, 32'h0, 3'b010, 1'b1, 1'b0, 1'b1, 1'b1, 5'd6);
    dmem_ready = 1'b1;
    @(negedge clk);
    drive_bubble(); dmem_ready = 1'b0;
    #1;
    tests_run++;
    if ({MEM_stall, dmem_req} !== 2'b10) begin
      tests_failed++;
      $display("FAIL resp_wait: stall=%b req=%b, required 1 0", MEM_stall, dmem_req);
    end
    reset = 1'b0;
    @(posedge clk); #1;
    tests_run++;
    if ({wb_obs(), MEM_misalign, dmem_req} !== 73'h0) begin
      tests_failed++;
      $display("FAIL resp_reset: wb=%h misalign=%b req=%b, required 0", wb_obs(), MEM_misalign, dmem_req);
    end
    @(negedge clk);
    reset = 1'b1; dmem_rvalid = 1'b1; dmem_rdata = 32'hFFFFFFFF;
    #1;
    tests_run++;
    if ({MEM_stall, dmem_req} !== 2'b00) begin
      tests_failed++;
      $display("FAIL stray_rvalid_comb: stall=%b req=%b, required 0 0", MEM_stall, dmem_req);
    end
    @(posedge clk); #1;
    tests_run++;
    if (wb_obs() !== 71'h0) begin
      tests_failed++;
      $display("FAIL stray_rvalid_wb: got %h required 0", wb_obs());
    end
    @(negedge clk);
    dmem_rvalid = 1'b0;
    drive_op(32'h55, 32'h0, 3'b000, 1'b0, 1'b0, 1'b0, 1'b1, 5'd3);
    @(posedge clk); #1;
    tests_run++;
    if (wb_obs() !== wb_exp(32'h55, 32'h0, 5'd3, 1'b1, 1'b0)) begin
      tests_failed++;
      $display("FAIL post_reset_alu: got %h required %h", wb_obs(), wb_exp(32'h55, 32'h0, 5'd3, 1'b1, 1'b0));
    end
    @(negedge clk); drive_bubble();
  endtask

  initial begin
    test_reset();
    test_alu_op();
    test_stores();
    test_store_wait();
    test_load_byte(3'b000, 32'hFFFFFF80, "lb");
    test_load_byte(3'b100, 32'h00000080, "lbu");
    test_load_wait();
    test_load_formats();
    test_misalign();
    test_reset_in_resp();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1);
  end

endmodule
